// File: rtl/x_seq_defs.sv
// Shared constants for the serial pattern detector.
// Default pattern geometry, counter width and FSM encodings.
package x_seq_defs;

    localparam int           DEF_PAT_LEN = 4;
    localparam logic [3:0]   DEF_PATTERN = 4'b1011;
    localparam int           DEF_CNT_W   = 8;

    localparam logic [0:0]   ST_FILL     = 1'b0;
    localparam logic [0:0]   ST_RUN      = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all ones; sat is registered alongside the count.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         sat
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic         sat_q;
    logic         sat_d;

    // next count: clear wins, otherwise step unless already saturated
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + W'(1);
        end
        sat_d = (q_d == '1);
    end

    // count and saturation flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= '0;
            sat_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            sat_q <= sat_d;
        end
    end

    assign q   = q_q;
    assign sat = sat_q;

endmodule

// File: rtl/x_seq_detector.sv
// Serial pattern detector on the x output of the a/b/c stage.
// Registered one-cycle detect pulse plus a saturating hit counter.
module x_seq_detector
    import x_seq_defs::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             x_valid,
    input  logic             x,
    output logic             detect,
    output logic [CNT_W-1:0] hit_count,
    output logic             count_sat
);

    localparam logic [3:0] FILL_MAX  = 4'(PAT_LEN);
    localparam logic [3:0] FILL_LAST = 4'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] shreg_q;
    logic [PAT_LEN-1:0] shreg_d;
    logic [3:0]         fill_q;
    logic [3:0]         fill_d;
    logic [0:0]         state_q;
    logic [0:0]         state_d;
    logic               detect_q;
    logic               detect_d;

    logic [PAT_LEN-1:0] next_bits;
    logic [3:0]         fill_inc;
    logic               cmp_en;
    logic               match;

    // compare the shifted-in history; enabled in RUN or on the filling bit
    always_comb begin
        next_bits = {shreg_q[PAT_LEN-2:0], x};
        fill_inc  = (fill_q == FILL_MAX) ? fill_q : fill_q + 4'd1;
        cmp_en    = (state_q == ST_RUN) || (fill_q == FILL_LAST);
        match     = x_valid && !clear && cmp_en
                    && (next_bits == PATTERN);
    end

    // history, fill level, FSM and pulse next-state
    always_comb begin
        shreg_d  = shreg_q;
        fill_d   = fill_q;
        state_d  = state_q;
        detect_d = 1'b0;
        if (clear) begin
            shreg_d = '0;
            fill_d  = '0;
            state_d = ST_FILL;
        end else if (x_valid) begin
            shreg_d = next_bits;
            fill_d  = fill_inc;
            state_d = (fill_inc == FILL_MAX) ? ST_RUN : ST_FILL;
            if (match) begin
                detect_d = 1'b1;
                if (!OVERLAP) begin
                    shreg_d = '0;
                    fill_d  = '0;
                    state_d = ST_FILL;
                end
            end
        end
    end

    // detector state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q  <= '0;
            fill_q   <= '0;
            state_q  <= ST_FILL;
            detect_q <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            fill_q   <= fill_d;
            state_q  <= state_d;
            detect_q <= detect_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_hits (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (match),
        .q   (hit_count),
        .sat (count_sat)
    );

    assign detect = detect_q;

endmodule
